// File: rtl/maxnet_pkg.sv
// Shared types and width helpers for the Maxnet winner-take-all engine.
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a channel sum: W bits plus enough headroom for N addends.
  function automatic int calc_cw(input int w, input int n);
    return w + $clog2(n);
  endfunction

  // Width of an iteration counter that must reach max_iter itself.
  function automatic int calc_iw(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/maxnet_cell.sv
// One channel of the Maxnet update: y_next = ReLU(y - (eps * sum_of_others) >> FRAC).
module maxnet_cell
  import maxnet_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int FRAC = 4
) (
  input  logic [W-1:0]              y_i,
  input  logic [calc_cw(W, N)-1:0]  total_i,
  input  logic [FRAC-1:0]           eps_i,
  output logic [W-1:0]              y_next_o,
  output logic                      nz_o
);

  localparam int CW = calc_cw(W, N);
  localparam int PW = CW + FRAC;

  logic [CW-1:0] y_ext;
  logic [CW-1:0] other;
  logic [PW-1:0] prod;
  logic [CW-1:0] penalty;

  assign y_ext   = CW'(y_i);
  assign other   = total_i - y_ext;
  assign prod    = PW'(eps_i) * PW'(other);
  assign penalty = prod[PW-1:FRAC];

  // When y > penalty the penalty is below 2^W, so its low W bits are exact.
  assign y_next_o = (y_ext > penalty) ? (y_i - penalty[W-1:0]) : '0;
  assign nz_o     = |y_i;

endmodule

// File: rtl/maxnet_engine.sv
// Maxnet winner-take-all engine: N parallel channel cells, iteration controller,
// start/done handshake, winner encode and timeout after MAX_ITER iterations.
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int FRAC     = 4,
  parameter int MAX_ITER = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N*W-1:0]                x,
  input  logic [FRAC-1:0]               epsilon,
  output logic                          busy,
  output logic                          done,
  output logic [N*W-1:0]                y_out,
  output logic                          winner_valid,
  output logic [$clog2(N)-1:0]          winner_idx,
  output logic                          timeout,
  output logic [calc_iw(MAX_ITER)-1:0]  iter_count
);

  localparam int CW  = calc_cw(W, N);
  localparam int IW  = calc_iw(MAX_ITER);
  localparam int XW  = $clog2(N);
  localparam int NZW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    y_q [N];
  logic [W-1:0]    y_d [N];
  logic [W-1:0]    y_next [N];
  logic [FRAC-1:0] eps_q, eps_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            wv_q, wv_d;
  logic [XW-1:0]   widx_q, widx_d;

  logic [CW-1:0]   total;
  logic [N-1:0]    nz;
  logic [NZW-1:0]  nz_cnt;
  logic [XW-1:0]   first_nz;

  for (genvar g = 0; g < N; g++) begin : g_cell
    maxnet_cell #(
      .W   (W),
      .N   (N),
      .FRAC(FRAC)
    ) u_cell (
      .y_i     (y_q[g]),
      .total_i (total),
      .eps_i   (eps_q),
      .y_next_o(y_next[g]),
      .nz_o    (nz[g])
    );
    assign y_out[g*W +: W] = y_q[g];
  end

  // Descending scan leaves first_nz at the lowest nonzero index.
  always_comb begin
    total    = '0;
    nz_cnt   = '0;
    first_nz = '0;
    for (int i = N - 1; i >= 0; i--) begin
      total  = total + CW'(y_q[i]);
      nz_cnt = nz_cnt + NZW'(nz[i]);
      if (nz[i]) first_nz = XW'(i);
    end
  end

  // NOTE: every *_d gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    eps_d     = eps_q;
    iter_d    = iter_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    wv_d      = wv_q;
    widx_d    = widx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < N; i++) y_d[i] = x[i*W +: W];
          eps_d     = epsilon;
          iter_d    = '0;
          timeout_d = 1'b0;
          wv_d      = 1'b0;
          widx_d    = '0;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (nz_cnt <= NZW'(1)) begin
          state_d = DONE;
          wv_d    = (nz_cnt == NZW'(1));
          widx_d  = first_nz;
        end else if (iter_q == IW'(MAX_ITER)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          wv_d      = 1'b0;
          widx_d    = '0;
        end else begin
          y_d    = y_next;
          iter_d = iter_q + IW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < N; i++) y_q[i] <= '0;
      eps_q     <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wv_q      <= 1'b0;
      widx_q    <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      eps_q     <= eps_d;
      iter_q    <= iter_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wv_q      <= wv_d;
      widx_q    <= widx_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign winner_valid = wv_q;
  assign winner_idx   = widx_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Scoreboard bench for maxnet_engine: a behavioural model predicts each run,
// the done monitor pops and compares values and completion cycle.
module tb_maxnet_engine;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int FRAC     = 4;
  localparam int MAX_ITER = 16;
  localparam int IW       = $clog2(MAX_ITER + 1);
  localparam int XW       = $clog2(N);

  typedef struct {
    logic [N*W-1:0] y;
    int             iters;
    logic           wv;
    int             widx;
    logic           to;
    int             done_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N*W-1:0]  x;
  logic [FRAC-1:0] epsilon;
  logic            busy;
  logic            done;
  logic [N*W-1:0]  y_out;
  logic            winner_valid;
  logic [XW-1:0]   winner_idx;
  logic            timeout;
  logic [IW-1:0]   iter_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t mon_e;

  maxnet_engine #(
    .N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .epsilon     (epsilon),
    .busy        (busy),
    .done        (done),
    .y_out       (y_out),
    .winner_valid(winner_valid),
    .winner_idx  (winner_idx),
    .timeout     (timeout),
    .iter_count  (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model(input logic [N*W-1:0] xv, input logic [FRAC-1:0] ev, output exp_t e);
    int y[N];
    int ny[N];
    int nz, idx, tot, p, it;
    for (int i = 0; i < N; i++) y[i] = int'(xv[i*W +: W]);
    it = 0; e.to = 1'b0; e.wv = 1'b0; e.widx = 0;
    while (1) begin
      nz = 0; idx = 0;
      for (int i = 0; i < N; i++) if (y[i] != 0) begin nz++; idx = i; end
      if (nz <= 1) begin
        e.wv = (nz == 1);
        e.widx = (nz == 1) ? idx : 0;
        break;
      end
      if (it == MAX_ITER) begin e.to = 1'b1; break; end
      tot = 0;
      for (int i = 0; i < N; i++) tot += y[i];
      for (int i = 0; i < N; i++) begin
        p = (int'(ev) * (tot - y[i])) / (1 << FRAC);
        ny[i] = (y[i] > p) ? y[i] - p : 0;
      end
      y = ny;
      it++;
    end
    e.iters = it;
    for (int i = 0; i < N; i++) e.y[i*W +: W] = y[i][W-1:0];
  endtask

  // Drives one accepted start and pushes its prediction; does not wait.
  task automatic launch(input logic [N*W-1:0] xv, input logic [FRAC-1:0] ev);
    exp_t e;
    model(xv, ev, e);
    @(negedge clk);
    start = 1'b1; x = xv; epsilon = ev;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = N*W'($urandom);
    epsilon = FRAC'($urandom);
    e.done_cyc = cyc + 2 + e.iters;
    sb.push_back(e);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_wait_bound", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_case(input logic [N*W-1:0] xv, input logic [FRAC-1:0] ev);
    launch(xv, ev);
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("y_out", y_out, mon_e.y);
        check("iter_count", iter_count, mon_e.iters);
        check("winner_valid", winner_valid, mon_e.wv);
        check("winner_idx", winner_idx, mon_e.widx);
        check("timeout", timeout, mon_e.to);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; epsilon = '0;
    #1;
    check("rst_y_out", y_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iter", iter_count, 0);
    check("rst_flags", {winner_valid, timeout, winner_idx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Channel 0 in the low byte.
    run_case({8'd40, 8'd30, 8'd20, 8'd10}, 4'd3);
    run_case({8'd0, 8'd77, 8'd0, 8'd0}, 4'd5);
    run_case({8'd0, 8'd0, 8'd50, 8'd50}, 4'd3);
    run_case('0, 4'd7);
    run_case({8'd4, 8'd3, 8'd2, 8'd1}, 4'd0);
    run_case({8'd255, 8'd255, 8'd255, 8'd255}, 4'd15);
    run_case({8'd255, 8'd254, 8'd1, 8'd0}, 4'd15);

    // A start while busy must be ignored and must not queue.
    launch({8'd40, 8'd30, 8'd20, 8'd10}, 4'd3);
    repeat (2) @(negedge clk);
    start = 1'b1; x = {8'd1, 8'd2, 8'd200, 8'd9}; epsilon = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    run_case({8'd1, 8'd2, 8'd200, 8'd9}, 4'd9);

    // Reset mid-run aborts at once with no done pulse.
    launch({8'd40, 8'd30, 8'd20, 8'd10}, 4'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("abort_y_out", y_out, 0);
    check("abort_busy", busy, 0);
    check("abort_iter", iter_count, 0);
    check("abort_flags", {done, winner_valid, timeout, winner_idx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_case({8'd40, 8'd30, 8'd20, 8'd10}, 4'd3);

    for (int k = 0; k < 6; k++) begin
      logic [N*W-1:0] xr;
      for (int i = 0; i < N; i++)
        xr[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom);
      run_case(xr, FRAC'($urandom_range(1, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
